rr_mux_arb: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with round-robin arbitration and a registered valid/ready output stage.
- Generalises the combinational 4:1 select mux: a fair arbiter chooses the source channel instead of an external select.
- Sits between multiple producer channels and a single consumer.
- Sustains one transfer per cycle with a one-cycle forward latency.

---
 rtl/rr_mux_arb.sv | 126 ++++++++++++
 tb/tb_rr_mux_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb
// N-channel, W-bit multiplexer. A round-robin arbiter picks the source channel,
// and a registered valid/ready output stage holds the chosen word. The stage
// moves one word per cycle and adds one cycle of forward latency.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset
//   in_valid   per-channel valid, bit k belongs to channel k
//   in_data    flattened channel data, channel k at [k*W +: W]
//   in_ready   per-channel ready (combinational, one-hot or all-zero)
//   out_valid  registered output valid
//   out_data   registered output data
//   out_ch     registered index of the channel that supplied out_data
//   out_ready  consumer ready
//
// Configuration:
//   RR_MUX_FIXED_PRIO_EN  when defined, the lowest-index requesting channel
//                         always wins and there is no round-robin pointer.

module rr_mux_arb #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CHW-1:0]   out_ch,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;

    logic [W-1:0]     ch_data [N];
    logic [CHW-1:0]   scan_base;
    logic [CHW-1:0]   cand;
    logic [CHW-1:0]   grant;
    logic             any_v;
    logic             load;

    for (genvar k = 0; k < N; k++) begin : g_split
        assign ch_data[k] = in_data[k*W +: W];
    end

`ifdef RR_MUX_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at channel 0.
    assign scan_base = '0;
`else
    logic [CHW-1:0]   ptr_q, ptr_d;
    assign scan_base = ptr_q;
`endif

    // The stage can take a new word when empty or when the current word leaves.
    assign load = ~out_valid_q | out_ready;

    // Scan channels starting at scan_base and wrapping past N-1 back to 0.
    // The modulo keeps every candidate inside 0..N-1 for any N.
    always_comb begin
        grant = '0;
        any_v = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = CHW'((int'(scan_base) + i) % N);
            if (!any_v && in_valid[cand]) begin
                any_v = 1'b1;
                grant = cand;
            end
        end
    end

    // Ready goes only to the granted channel. It is forced low during reset.
    assign in_ready = (load && any_v && !rst) ? (N'(1) << grant) : '0;

    // Next state: load a granted word, drain to empty when nothing is
    // requested, and hold everything while the consumer stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
`ifndef RR_MUX_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        if (load) begin
            if (any_v) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[grant];
                out_ch_d    = grant;
`ifndef RR_MUX_FIXED_PRIO_EN
                ptr_d       = (int'(grant) == N - 1) ? '0 : CHW'(int'(grant) + 1);
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
`ifndef RR_MUX_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb
// Self-checking bench for rr_mux_arb with N=4 and W=8. It runs three parts:
// a reset check, a table of directed vectors, and hand-written sequences for
// the async reset corner. Randomized traffic follows, and a queue-free
// behavioural model of the arbitration rules checks every cycle.

module tb_rr_mux_arb;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [CHW-1:0]   out_ch;
    logic             out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: what the output register and pointer should hold.
    logic             m_valid;
    logic [W-1:0]     m_data;
    int               m_ch;
    int               m_ptr;
    logic [N-1:0]     sampled_ready;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        logic           rdy;
        logic [N-1:0]   exp_ready;
        logic           exp_ov;
        logic [W-1:0]   exp_data;
        logic [CHW-1:0] exp_ch;
    } vec_t;

    vec_t tbl [17];

    rr_mux_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // The grant goes to the first requesting channel, counting from base
    // and wrapping at N-1. The function returns -1 when nobody requests.
    function automatic int pick(input int base, input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (((v >> ((base + off) % N)) & 1) != 0) return (base + off) % N;
        end
        return -1;
    endfunction

    // Run one clock cycle. The task starts at a falling edge with the inputs
    // already driven. It checks in_ready before the rising edge and the
    // registered outputs just after it.
    task automatic stepCycle();
        logic          load;
        int            g;
        int            base;
        logic [N-1:0]  exp_ready;
        logic          nv;
        logic [W-1:0]  nd;
        int            nc;
        int            np;
        #1;
`ifdef RR_MUX_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        load      = !m_valid || out_ready;
        g         = pick(base, in_valid);
        exp_ready = (load && g >= 0) ? N'(1 << g) : '0;
        sampled_ready = in_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        nv = m_valid; nd = m_data; nc = m_ch; np = m_ptr;
        if (load) begin
            if (g >= 0) begin
                nv = 1'b1;
                nd = W'(in_data >> (g * W));
                nc = g;
                np = (g + 1) % N;
            end else begin
                nv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_data = nd; m_ch = nc; m_ptr = np;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_data",  32'(out_data),  32'(m_data));
        checkOutput("out_ch",    32'(out_ch),    32'(m_ch));
        @(negedge clk);
    endtask

    initial begin
        // Directed vectors. Channel data is 0x10, 0x21, 0x32, 0x43 unless noted.
        tbl[0]  = '{4'b1111, 32'h43322110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[1]  = '{4'b1111, 32'h43322110, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1};
        tbl[2]  = '{4'b1111, 32'h43322110, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2};
        tbl[3]  = '{4'b1111, 32'h43322110, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3};
        tbl[4]  = '{4'b1111, 32'h43322110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[5]  = '{4'b0100, 32'h43322110, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2};
        tbl[6]  = '{4'b0101, 32'h43322110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[7]  = '{4'b0101, 32'h43322110, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2};
        tbl[8]  = '{4'b0101, 32'h43322110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[9]  = '{4'b0010, 32'h43322110, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1};
        tbl[10] = '{4'b1111, 32'h43322110, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1};
        tbl[11] = '{4'b1111, 32'h43322110, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1};
        tbl[12] = '{4'b1111, 32'h43322110, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1};
        tbl[13] = '{4'b1111, 32'h43322110, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2};
        tbl[14] = '{4'b0100, 32'h435A2110, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2};
        tbl[15] = '{4'b0000, 32'h435A2110, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2};
        tbl[16] = '{4'b0000, 32'h435A2110, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2};

        // Reset held with every channel requesting.
        rst = 1'b1;
        modelReset();
        applyStimulus(4'b1111, 32'h43322110, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready",  32'(in_ready),  32'h0);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset out_data",  32'(out_data),  32'h0);
        checkOutput("reset out_ch",    32'(out_ch),    32'h0);
        rst = 1'b0;

`ifndef RR_MUX_FIXED_PRIO_EN
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].data, tbl[i].rdy);
            stepCycle();
            checkOutput($sformatf("vec%0d in_ready", i),  32'(sampled_ready), 32'(tbl[i].exp_ready));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid),     32'(tbl[i].exp_ov));
            checkOutput($sformatf("vec%0d out_data", i),  32'(out_data),      32'(tbl[i].exp_data));
            checkOutput($sformatf("vec%0d out_ch", i),    32'(out_ch),        32'(tbl[i].exp_ch));
        end
`else
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1111, 32'h43322110, 1'b1);
            stepCycle();
            checkOutput($sformatf("fixed%0d out_ch", i),   32'(out_ch),   32'h0);
            checkOutput($sformatf("fixed%0d out_data", i), 32'(out_data), 32'h10);
        end
`endif

        // Reset asserted between edges while a word stalls at the output.
        applyStimulus(4'b1111, 32'h43322110, 1'b1);
        stepCycle();
        applyStimulus(4'b1111, 32'h43322110, 1'b0);
        stepCycle();
        checkOutput("stall out_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", 32'(out_valid), 32'h0);
        checkOutput("async rst in_ready",  32'(in_ready),  32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1111, 32'h43322110, 1'b1);
        stepCycle();
        checkOutput("post rst out_ch",   32'(out_ch),   32'h0);
        checkOutput("post rst out_data", 32'(out_data), 32'h10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(N'($urandom), $urandom, ($urandom_range(0, 3) != 0));
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
